// File: rtl/vga_draw_pkg.sv
// Shared definitions for the VGA drawing engines: screen geometry per
// resolution, coordinate widths, colour width and the engine state encoding.
package vga_draw_pkg;

    localparam int COLOUR_BITS = 12;

    localparam int XMAX_HI = 320;
    localparam int YMAX_HI = 240;
    localparam int XMAX_LO = 160;
    localparam int YMAX_LO = 120;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } draw_state_t;

    // Geometry lookups keyed on whether the build is the 160x120 variant.
    function automatic int xmax_of(input bit low_res);
        return low_res ? XMAX_LO : XMAX_HI;
    endfunction

    function automatic int ymax_of(input bit low_res);
        return low_res ? YMAX_LO : YMAX_HI;
    endfunction

    function automatic int x_bits_of(input bit low_res);
        return low_res ? 8 : 9;
    endfunction

    function automatic int y_bits_of(input bit low_res);
        return low_res ? 7 : 8;
    endfunction

endpackage

// File: rtl/rect_fill_engine_clip.sv
// Rectangle-to-screen clipper. Purely combinational; returns the last
// on-screen column/row of a rectangle and whether nothing of it is visible.
// Shared by the fill, line and sprite engines.
module rect_clip
    import vga_draw_pkg::*;
#(
    parameter int X_BITS = 9,
    parameter int Y_BITS = 8,
    parameter int XMAX   = XMAX_HI,
    parameter int YMAX   = YMAX_HI
) (
    input  logic [X_BITS-1:0] x0,
    input  logic [Y_BITS-1:0] y0,
    input  logic [X_BITS-1:0] width,
    input  logic [Y_BITS-1:0] height,
    output logic [X_BITS-1:0] x_last,
    output logic [Y_BITS-1:0] y_last,
    output logic              empty
);

    localparam logic [X_BITS:0] X_LIM   = (X_BITS+1)'(XMAX - 1);
    localparam logic [Y_BITS:0] Y_LIM   = (Y_BITS+1)'(YMAX - 1);
    localparam logic [X_BITS:0] X_SCR   = (X_BITS+1)'(XMAX);
    localparam logic [Y_BITS:0] Y_SCR   = (Y_BITS+1)'(YMAX);
    localparam logic [X_BITS:0] X_ONE   = (X_BITS+1)'(1);
    localparam logic [Y_BITS:0] Y_ONE   = (Y_BITS+1)'(1);

    logic [X_BITS:0] x_end;
    logic [Y_BITS:0] y_end;

    // End coordinates computed one bit wider so a far-right/bottom rectangle
    // cannot wrap back on screen; a zero size wraps but is flagged empty.
    always_comb begin
        x_end  = {1'b0, x0} + {1'b0, width} - X_ONE;
        y_end  = {1'b0, y0} + {1'b0, height} - Y_ONE;
        x_last = (x_end > X_LIM) ? X_LIM[X_BITS-1:0] : x_end[X_BITS-1:0];
        y_last = (y_end > Y_LIM) ? Y_LIM[Y_BITS-1:0] : y_end[Y_BITS-1:0];
        empty  = (width == '0) || (height == '0) ||
                 ({1'b0, x0} >= X_SCR) || ({1'b0, y0} >= Y_SCR);
    end

endmodule

// File: rtl/rect_fill_engine.sv
// Rectangle fill engine feeding the VGA adapter write port. Walks the
// clipped rectangle in raster order, one dot per clock, then pulses done.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for start; inputs latched and clipped on acceptance
// FILL    | plotting one dot per cycle (or a single plot-less busy cycle
//         | when the request clipped to nothing)
// DONE    | done=1 for exactly one cycle, start ignored, then IDLE
module rect_fill_engine #(
    parameter RESOLUTION      = "320x240",
    parameter int COLOUR_BITS = vga_draw_pkg::COLOUR_BITS,
    parameter int X_BITS      = vga_draw_pkg::x_bits_of(RESOLUTION == "160x120"),
    parameter int Y_BITS      = vga_draw_pkg::y_bits_of(RESOLUTION == "160x120")
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [X_BITS-1:0]      x0,
    input  logic [Y_BITS-1:0]      y0,
    input  logic [X_BITS-1:0]      width,
    input  logic [Y_BITS-1:0]      height,
    input  logic [COLOUR_BITS-1:0] colour_in,
    output logic [X_BITS-1:0]      x,
    output logic [Y_BITS-1:0]      y,
    output logic [COLOUR_BITS-1:0] colour,
    output logic                   plot,
    output logic                   busy,
    output logic                   done
);

    import vga_draw_pkg::*;

    localparam bit LOW_RES = (RESOLUTION == "160x120");
    localparam int XMAX    = xmax_of(LOW_RES);
    localparam int YMAX    = ymax_of(LOW_RES);

    draw_state_t       state;
    logic [X_BITS-1:0] x_first;
    logic [X_BITS-1:0] x_last_r;
    logic [Y_BITS-1:0] y_last_r;
    logic              pend_empty;

    logic [X_BITS-1:0] clip_x_last;
    logic [Y_BITS-1:0] clip_y_last;
    logic              clip_empty;

    rect_clip #(
        .X_BITS (X_BITS),
        .Y_BITS (Y_BITS),
        .XMAX   (XMAX),
        .YMAX   (YMAX)
    ) u_clip (
        .x0     (x0),
        .y0     (y0),
        .width  (width),
        .height (height),
        .x_last (clip_x_last),
        .y_last (clip_y_last),
        .empty  (clip_empty)
    );

    // Sequencer with registered adapter outputs; x/y/colour only move while
    // dots are being plotted and hold otherwise.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            x          <= '0;
            y          <= '0;
            colour     <= '0;
            plot       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            x_first    <= '0;
            x_last_r   <= '0;
            y_last_r   <= '0;
            pend_empty <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state      <= ST_FILL;
                        busy       <= 1'b1;
                        pend_empty <= clip_empty;
                        plot       <= !clip_empty;
                        if (!clip_empty) begin
                            x_first  <= x0;
                            x_last_r <= clip_x_last;
                            y_last_r <= clip_y_last;
                            x        <= x0;
                            y        <= y0;
                            colour   <= colour_in;
                        end
                    end
                end
                ST_FILL: begin
                    if (pend_empty) begin
                        pend_empty <= 1'b0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        state      <= ST_DONE;
                    end else if (x == x_last_r) begin
                        if (y == y_last_r) begin
                            plot  <= 1'b0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            x <= x_first;
                            y <= y + 1'b1;
                        end
                    end else begin
                        x <= x + 1'b1;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    plot  <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rect_fill_engine.sv
// Self-checking bench for rect_fill_engine: a 320x240 instance and a 160x120
// instance, each with a dot scoreboard fed by an independent raster model.
module tb_rect_fill_engine;

    typedef struct {
        int x;
        int y;
        int c;
    } dot_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start_a = 1'b0;
    logic        start_b = 1'b0;
    logic [8:0]  x0 = '0;
    logic [7:0]  y0 = '0;
    logic [8:0]  width = '0;
    logic [7:0]  height = '0;
    logic [11:0] colour_in = '0;

    logic [8:0]  xa;
    logic [7:0]  ya;
    logic [11:0] ca;
    logic        plot_a, busy_a, done_a;
    logic [7:0]  xb;
    logic [6:0]  yb;
    logic [11:0] cb;
    logic        plot_b, busy_b, done_b;

    dot_t qa[$];
    dot_t qb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clock = ~clock;

    rect_fill_engine #(.RESOLUTION("320x240")) dut_a (
        .clock(clock), .reset(reset), .start(start_a),
        .x0(x0), .y0(y0), .width(width), .height(height), .colour_in(colour_in),
        .x(xa), .y(ya), .colour(ca), .plot(plot_a), .busy(busy_a), .done(done_a)
    );

    rect_fill_engine #(.RESOLUTION("160x120")) dut_b (
        .clock(clock), .reset(reset), .start(start_b),
        .x0(x0[7:0]), .y0(y0[6:0]), .width(width[7:0]), .height(height[6:0]),
        .colour_in(colour_in),
        .x(xb), .y(yb), .colour(cb), .plot(plot_b), .busy(busy_b), .done(done_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard consumers: every plotted dot must match the next expected one.
    always @(negedge clock) begin
        dot_t d;
        if (plot_a) begin
            if (qa.size() == 0) chk("a_unexpected_plot", 1, 0);
            else begin
                d = qa.pop_front();
                chk("a_x", 32'(xa), d.x);
                chk("a_y", 32'(ya), d.y);
                chk("a_colour", 32'(ca), d.c);
            end
        end
    end

    always @(negedge clock) begin
        dot_t d;
        if (plot_b) begin
            if (qb.size() == 0) chk("b_unexpected_plot", 1, 0);
            else begin
                d = qb.pop_front();
                chk("b_x", 32'(xb), d.x);
                chk("b_y", 32'(yb), d.y);
                chk("b_colour", 32'(cb), d.c);
            end
        end
    end

    // Push the clipped raster of a rectangle; returns the dot count.
    task automatic push_rect(input bit use_b, input int rx0, input int ry0,
                             input int rw, input int rh, input int rc, output int cnt);
        int   xm;
        int   ym;
        int   xe;
        int   ye;
        dot_t d;
        xm  = use_b ? 160 : 320;
        ym  = use_b ? 120 : 240;
        xe  = (rx0 + rw < xm) ? rx0 + rw : xm;
        ye  = (ry0 + rh < ym) ? ry0 + rh : ym;
        cnt = 0;
        for (int yy = ry0; yy < ye; yy++) begin
            for (int xx = rx0; xx < xe; xx++) begin
                d.x = xx; d.y = yy; d.c = rc;
                if (use_b) qb.push_back(d); else qa.push_back(d);
                cnt++;
            end
        end
    endtask

    task automatic drive_start(input bit use_b, input int rx0, input int ry0,
                               input int rw, input int rh, input int rc);
        @(negedge clock);
        x0 = 9'(rx0); y0 = 8'(ry0); width = 9'(rw); height = 8'(rh);
        colour_in = 12'(rc);
        if (use_b) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clock);
        start_a = 1'b0; start_b = 1'b0;
        x0 = 9'($urandom); y0 = 8'($urandom); width = 9'($urandom);
        height = 8'($urandom); colour_in = 12'($urandom);
    endtask

    // One complete request with cycle-by-cycle plot/busy/done checks.
    task automatic run_rect(input bit use_b, input int rx0, input int ry0,
                            input int rw, input int rh, input int rc, input bit mid_start);
        int cnt;
        int done_cyc;
        push_rect(use_b, rx0, ry0, rw, rh, rc, cnt);
        done_cyc = (cnt == 0) ? 2 : cnt + 1;
        drive_start(use_b, rx0, ry0, rw, rh, rc);
        for (int cyc = 1; cyc <= done_cyc; cyc++) begin
            if (cyc > 1) @(negedge clock);
            if (mid_start && cyc == 100) begin
                x0 = 9'd3; y0 = 8'd3; width = 9'd2; height = 8'd2;
                if (use_b) start_b = 1'b1; else start_a = 1'b1;
            end
            if (mid_start && cyc == 101) begin
                start_a = 1'b0; start_b = 1'b0;
            end
            chk("plot", 32'(use_b ? plot_b : plot_a), 32'(cyc <= cnt));
            chk("busy", 32'(use_b ? busy_b : busy_a), 32'(cyc < done_cyc));
            chk("done", 32'(use_b ? done_b : done_a), 32'(cyc == done_cyc));
        end
        chk("dots_remaining", use_b ? qb.size() : qa.size(), 0);
        @(negedge clock);
        chk("done_one_cycle", 32'(use_b ? done_b : done_a), 0);
        chk("plot_after_done", 32'(use_b ? plot_b : plot_a), 0);
    endtask

    task automatic check_zero_a(input string tag);
        chk({tag, "_x"}, 32'(xa), 0);
        chk({tag, "_y"}, 32'(ya), 0);
        chk({tag, "_colour"}, 32'(ca), 0);
        chk({tag, "_plot"}, 32'(plot_a), 0);
        chk({tag, "_busy"}, 32'(busy_a), 0);
        chk({tag, "_done"}, 32'(done_a), 0);
    endtask

    initial begin
        int cnt;
        int n_done;

        // Reset held for two cycles: every output at 0.
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_zero_a("rst");
        chk("rst_b_plot", 32'(plot_b), 0);
        chk("rst_b_done", 32'(done_b), 0);
        reset = 1'b0;

        run_rect(1'b0, 10, 20, 3, 2, 'hF00, 1'b0);
        run_rect(1'b0, 318, 238, 5, 5, 'hABC, 1'b0);
        run_rect(1'b0, 5, 5, 0, 7, 'h123, 1'b0);
        run_rect(1'b0, 320, 5, 4, 4, 'h456, 1'b0);
        run_rect(1'b0, 7, 240, 3, 3, 'h789, 1'b0);
        run_rect(1'b0, 0, 0, 320, 240, 'h000, 1'b1);

        // Abort: reset sampled at the end of the 5th plot cycle of a 4x4 fill.
        push_rect(1'b0, 40, 50, 4, 4, 'h0F0, cnt);
        drive_start(1'b0, 40, 50, 4, 4, 'h0F0);
        for (int cyc = 1; cyc <= 5; cyc++) begin
            if (cyc > 1) @(negedge clock);
            chk("abort_plot", 32'(plot_a), 1);
        end
        reset = 1'b1;
        @(posedge clock);
        #1 qa.delete();
        @(negedge clock);
        check_zero_a("abort");
        reset = 1'b0;
        n_done = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (done_a || plot_a) n_done++;
        end
        chk("abort_no_done", n_done, 0);
        run_rect(1'b0, 5, 5, 1, 1, 'h00F, 1'b0);

        // Low-resolution build clips to 160x120.
        run_rect(1'b1, 150, 110, 20, 20, 'h5A5, 1'b0);
        run_rect(1'b1, 0, 0, 3, 2, 'hFFF, 1'b0);

        repeat (3) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
